// File: rtl/vga_layer_stack.sv
// vga_layer_stack: priority compositor for N layer channels with frame-aligned enables and collision report
module vga_layer_stack #(
  parameter int LAYERS = 7,
  parameter int RGB_W = 12,
  parameter int COUNT_W = 11,
  parameter logic [RGB_W-1:0] BG_RGB = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [COUNT_W-1:0]      hcount_in,
  input  logic [COUNT_W-1:0]      vcount_in,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  input  logic                    hblnk_in,
  input  logic                    vblnk_in,
  input  logic [LAYERS*RGB_W-1:0] layer_rgb,
  input  logic [LAYERS-1:0]       layer_opaque,
  input  logic [LAYERS-1:0]       layer_en,
  output logic                    hs,
  output logic                    vs,
  output logic [RGB_W-1:0]        rgb,
  output logic [COUNT_W-1:0]      hcount_out,
  output logic [COUNT_W-1:0]      vcount_out,
  output logic                    frame_tick,
  output logic [LAYERS-1:0]       collision,
  output logic [LAYERS-1:0]       en_active
);
  localparam int PC_W = $clog2(LAYERS) + 1;
  logic [COUNT_W-1:0]      hcount_q, vcount_q, hcount_out_q, vcount_out_q;
  logic                    hsync_q, vsync_q, hblnk_q, vblnk_q, hs_q, vs_q;
  logic [LAYERS*RGB_W-1:0] lrgb_q;
  logic [LAYERS-1:0]       opq_q, en_q, en_d, coll_acc_q, coll_acc_d, coll_q, coll_d;
  logic [LAYERS-1:0]       eff, contrib;
  logic [RGB_W-1:0]        rgb_q, rgb_d, sel;
  logic [PC_W-1:0]         pc;
  logic                    tick_q, rise;
  // pick the highest-index enabled opaque layer and count how many overlap
  always_comb begin
    eff = opq_q & en_q;
    pc = '0;
    sel = BG_RGB;
    for (int k = 0; k < LAYERS; k++) begin
      pc = pc + PC_W'(eff[k]);
      sel = eff[k] ? lrgb_q[k*RGB_W +: RGB_W] : sel;
    end
    contrib = (!hblnk_q && !vblnk_q && pc >= PC_W'(2)) ? eff : '0;
    rise = vblnk_in & ~vblnk_q;
    rgb_d = (hblnk_q || vblnk_q) ? '0 : sel;
    en_d = rise ? layer_en : en_q;
    coll_d = rise ? (coll_acc_q | contrib) : coll_q;
    coll_acc_d = rise ? '0 : (coll_acc_q | contrib);
  end
  // stage 1: capture timing and layer inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_q <= '0;
      vcount_q <= '0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      hblnk_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      lrgb_q   <= '0;
      opq_q    <= '0;
    end else begin
      hcount_q <= hcount_in;
      vcount_q <= vcount_in;
      hsync_q  <= hsync_in;
      vsync_q  <= vsync_in;
      hblnk_q  <= hblnk_in;
      vblnk_q  <= vblnk_in;
      lrgb_q   <= layer_rgb;
      opq_q    <= layer_opaque;
    end
  end
  // stage 2: registered composited pixel and aligned timing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      rgb_q        <= '0;
      hcount_out_q <= '0;
      vcount_out_q <= '0;
    end else begin
      hs_q         <= hsync_q;
      vs_q         <= vsync_q;
      rgb_q        <= rgb_d;
      hcount_out_q <= hcount_q;
      vcount_out_q <= vcount_q;
    end
  end
  // frame boundary: latch enables, publish collisions, pulse the tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q       <= '1;
      coll_q     <= '0;
      coll_acc_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      en_q       <= en_d;
      coll_q     <= coll_d;
      coll_acc_q <= coll_acc_d;
      tick_q     <= rise;
    end
  end
  assign hs = hs_q;
  assign vs = vs_q;
  assign rgb = rgb_q;
  assign hcount_out = hcount_out_q;
  assign vcount_out = vcount_out_q;
  assign frame_tick = tick_q;
  assign collision = coll_q;
  assign en_active = en_q;
endmodule

// File: tb/tb_vga_layer_stack.sv
// tb_vga_layer_stack: directed checks of priority, blanking, deferred enables, collisions and reset
module tb_vga_layer_stack;
  localparam int L = 7;
  localparam int W = 12;
  localparam int C = 11;
  localparam logic [W-1:0] BG = 12'h0A5;
  logic clk = 1'b0, rst = 1'b1;
  logic [C-1:0] hcount_in = '0, vcount_in = '0, hcount_out, vcount_out;
  logic hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b1, vblnk_in = 1'b1;
  logic [L*W-1:0] layer_rgb;
  logic [L-1:0] layer_opaque = '0, layer_en = '1, collision, en_active;
  logic hs, vs, frame_tick;
  logic [W-1:0] rgb;
  int errors = 0, checks = 0;
  vga_layer_stack #(.LAYERS(L), .RGB_W(W), .COUNT_W(C), .BG_RGB(BG)) dut (
    .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .layer_rgb(layer_rgb), .layer_opaque(layer_opaque), .layer_en(layer_en),
    .hs(hs), .vs(vs), .rgb(rgb), .hcount_out(hcount_out), .vcount_out(vcount_out),
    .frame_tick(frame_tick), .collision(collision), .en_active(en_active)
  );
  always #12 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    for (int k = 0; k < L; k++) layer_rgb[k*W +: W] = W'(12'h100 * k + 1);
    tick(5);
    chk("rst_rgb", 32'(rgb), 32'h0);
    chk("rst_hs", 32'(hs), 32'h0);
    chk("rst_vs", 32'(vs), 32'h0);
    chk("rst_en", 32'(en_active), 32'h7F);
    chk("rst_coll", 32'(collision), 32'h0);
    chk("rst_tick", 32'(frame_tick), 32'h0);
    rst = 1'b0;
    tick(3);
    chk("post_rst_en", 32'(en_active), 32'h7F);
    // frame A: priority
    vblnk_in = 1'b0; hblnk_in = 1'b0; hsync_in = 1'b1; hcount_in = 11'd5; vcount_in = 11'd9;
    layer_opaque = 7'b0010011;
    tick(1);
    chk("lat1_rgb", 32'(rgb), 32'h0);
    tick(1);
    chk("prio_rgb", 32'(rgb), 32'h401);
    chk("prio_hc", 32'(hcount_out), 32'd5);
    chk("prio_vc", 32'(vcount_out), 32'd9);
    chk("prio_hs", 32'(hs), 32'h1);
    layer_opaque = '0;
    tick(2);
    chk("bg_rgb", 32'(rgb), 32'(BG));
    // blanking
    layer_opaque = 7'b0010011; hblnk_in = 1'b1; hsync_in = 1'b0;
    tick(1);
    chk("blank_hs_hold", 32'(hs), 32'h1);
    tick(1);
    chk("blank_hs", 32'(hs), 32'h0);
    chk("blank_rgb", 32'(rgb), 32'h0);
    // deferred enable
    hblnk_in = 1'b0; layer_en = 7'h01; layer_opaque = 7'h10;
    tick(2);
    chk("defer_rgb", 32'(rgb), 32'h401);
    chk("defer_en", 32'(en_active), 32'h7F);
    vblnk_in = 1'b1;
    tick(1);
    chk("A_tick", 32'(frame_tick), 32'h1);
    chk("A_en", 32'(en_active), 32'h01);
    chk("A_coll", 32'(collision), 32'h13);
    tick(1);
    chk("A_tick_off", 32'(frame_tick), 32'h0);
    // frame B: disabled layers never flag
    vblnk_in = 1'b0; layer_opaque = 7'h10;
    tick(2);
    chk("B_bg", 32'(rgb), 32'(BG));
    layer_opaque = 7'b0000110; layer_en = 7'h7F;
    tick(1);
    layer_opaque = '0;
    tick(2);
    vblnk_in = 1'b1;
    tick(1);
    chk("B_coll", 32'(collision), 32'h0);
    chk("B_en", 32'(en_active), 32'h7F);
    // frame C: one overlap pixel
    tick(2);
    vblnk_in = 1'b0; layer_opaque = 7'b0000110;
    tick(1);
    layer_opaque = 7'b1000000;
    tick(1);
    chk("C_rgb", 32'(rgb), 32'h201);
    tick(1);
    chk("C_rgb6", 32'(rgb), 32'h601);
    chk("C_notick", 32'(frame_tick), 32'h0);
    layer_en = 7'h55;
    vblnk_in = 1'b1;
    tick(1);
    chk("C_coll", 32'(collision), 32'h06);
    chk("C_tick", 32'(frame_tick), 32'h1);
    tick(1);
    chk("C_tick_once", 32'(frame_tick), 32'h0);
    // frame D: no overlap
    tick(2);
    vblnk_in = 1'b0; layer_opaque = 7'b1000000;
    tick(3);
    vblnk_in = 1'b1;
    tick(1);
    chk("D_coll", 32'(collision), 32'h0);
    chk("D_en", 32'(en_active), 32'h55);
    // frame E: reset mid-frame
    tick(2);
    vblnk_in = 1'b0; layer_opaque = 7'b0010011; hsync_in = 1'b1; hcount_in = 11'd77;
    tick(2);
    chk("E_rgb", 32'(rgb), 32'h401);
    rst = 1'b1;
    #1;
    chk("mrst_rgb", 32'(rgb), 32'h0);
    chk("mrst_hs", 32'(hs), 32'h0);
    chk("mrst_hc", 32'(hcount_out), 32'h0);
    chk("mrst_en", 32'(en_active), 32'h7F);
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("mrst_notick", 32'(frame_tick), 32'h0);
    end
    chk("mrst_en_hold", 32'(en_active), 32'h7F);
    chk("mrst_rgb_after", 32'(rgb), 32'h401);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
